// File: rtl/reaction_game_ctrl.sv
// -----------------------------------------------------------------------------
// reaction_game_ctrl
//
// Purpose:
//   Single-player reaction-game controller for one game slot. After a start
//   pulse it waits DELAY_CYCLES unpaused cycles, then lights the target for
//   WINDOW_CYCLES unpaused cycles.
//     - A hit while the target is lit scores a point.
//     - A hit before the target lights counts as a miss.
//     - Letting the window expire also counts as a miss.
//   The game ends in WIN after WIN_SCORE hits, or in LOSE after MAX_MISSES
//   misses.
//
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous, active-low reset
//   start      in   1  pulse; begins a new game from IDLE, WIN or LOSE
//   pause      in   1  level; freezes play while waiting or armed
//   hit        in   1  pulse from the player button edge detector
//   game_state out  2  00 idle/running/paused, 01 win, 10 lose
//   target     out  1  target LED drive (armed and not paused)
//   score      out  8  hits in the current game
//   misses     out  8  misses in the current game
// -----------------------------------------------------------------------------
module reaction_game_ctrl #(
    parameter int unsigned DELAY_CYCLES  = 50_000_000,
    parameter int unsigned WINDOW_CYCLES = 25_000_000,
    parameter int unsigned WIN_SCORE     = 5,
    parameter int unsigned MAX_MISSES    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       hit,
    output logic [1:0] game_state,
    output logic       target,
    output logic [7:0] score,
    output logic [7:0] misses
);

    // The counter only has to reach the larger of the two reload values,
    // which are both "cycles - 1". It is never narrower than one bit.
    localparam int unsigned CNT_MAX = (DELAY_CYCLES > WINDOW_CYCLES) ? DELAY_CYCLES : WINDOW_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [7:0]       WIN_LIMIT   = 8'(WIN_SCORE);
    localparam logic [7:0]       MISS_LIMIT  = 8'(MAX_MISSES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    // Encoding of the 2-bit status word seen by the LED status stage.
    function automatic logic [1:0] state_code(input state_t st);
        logic [1:0] code;
        case (st)
            ST_WIN:  code = 2'b01;
            ST_LOSE: code = 2'b10;
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       score_r;
    logic [7:0]       misses_r;
    logic [1:0]       game_state_r;

    logic [7:0]       score_inc_s;
    logic [7:0]       misses_inc_s;

    // Incremented counts; terminal states are entered exactly at the limits,
    // so neither of these can wrap in practice.
    assign score_inc_s  = score_r + 8'd1;
    assign misses_inc_s = misses_r + 8'd1;

    // Game FSM: state, phase counter, score/miss tallies and the registered
    // status word all advance together on the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            count_r      <= CNT_ZERO;
            score_r      <= 8'd0;
            misses_r     <= 8'd0;
            game_state_r <= 2'b00;
        end else begin
            case (state_r)
                // Between games only start matters; a simultaneous hit is
                // dropped. WIN/LOSE keep their tallies visible until then.
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        state_r      <= ST_WAIT;
                        count_r      <= DELAY_LOAD;
                        score_r      <= 8'd0;
                        misses_r     <= 8'd0;
                        game_state_r <= state_code(ST_WAIT);
                    end else begin
                        state_r      <= state_r;
                        count_r      <= count_r;
                    end
                end

                // Delay before the target lights. Any unpaused hit here is
                // early, including one on the final delay cycle.
                ST_WAIT: begin
                    if (pause) begin
                        count_r <= count_r;
                    end else if (hit) begin
                        misses_r <= misses_inc_s;
                        if (misses_inc_s == MISS_LIMIT) begin
                            state_r      <= ST_LOSE;
                            game_state_r <= state_code(ST_LOSE);
                        end else begin
                            state_r      <= ST_WAIT;
                            count_r      <= DELAY_LOAD;
                            game_state_r <= state_code(ST_WAIT);
                        end
                    end else if (count_r == CNT_ZERO) begin
                        state_r      <= ST_ARMED;
                        count_r      <= WINDOW_LOAD;
                        game_state_r <= state_code(ST_ARMED);
                    end else begin
                        count_r <= count_r - CNT_ONE;
                    end
                end

                // Target lit. The hit check comes before the timeout check so
                // a hit on the last window cycle still scores.
                ST_ARMED: begin
                    if (pause) begin
                        count_r <= count_r;
                    end else if (hit) begin
                        score_r <= score_inc_s;
                        if (score_inc_s == WIN_LIMIT) begin
                            state_r      <= ST_WIN;
                            game_state_r <= state_code(ST_WIN);
                        end else begin
                            state_r      <= ST_WAIT;
                            count_r      <= DELAY_LOAD;
                            game_state_r <= state_code(ST_WAIT);
                        end
                    end else if (count_r == CNT_ZERO) begin
                        misses_r <= misses_inc_s;
                        if (misses_inc_s == MISS_LIMIT) begin
                            state_r      <= ST_LOSE;
                            game_state_r <= state_code(ST_LOSE);
                        end else begin
                            state_r      <= ST_WAIT;
                            count_r      <= DELAY_LOAD;
                            game_state_r <= state_code(ST_WAIT);
                        end
                    end else begin
                        count_r <= count_r - CNT_ONE;
                    end
                end

                // Unreachable encodings recover to the reset condition.
                default: begin
                    state_r      <= ST_IDLE;
                    count_r      <= CNT_ZERO;
                    score_r      <= 8'd0;
                    misses_r     <= 8'd0;
                    game_state_r <= 2'b00;
                end
            endcase
        end
    end

    // The target LED follows the pause level directly so a paused window
    // goes dark in the same cycle the player pauses.
    assign target     = (state_r == ST_ARMED) && !pause;
    assign game_state = game_state_r;
    assign score      = score_r;
    assign misses     = misses_r;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reaction_game_ctrl
//
// Directed bench for reaction_game_ctrl with DELAY_CYCLES=4, WINDOW_CYCLES=3,
// WIN_SCORE=2, MAX_MISSES=2. Inputs change 1 ns after a rising edge; outputs
// are sampled at that same point, so each check sees the result of the most
// recent edge.
// -----------------------------------------------------------------------------
module tb_reaction_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       hit = 1'b0;
    logic [1:0] game_state;
    logic       target;
    logic [7:0] score;
    logic [7:0] misses;

    int tests = 0;
    int fails = 0;

    reaction_game_ctrl #(
        .DELAY_CYCLES (4),
        .WINDOW_CYCLES(3),
        .WIN_SCORE    (2),
        .MAX_MISSES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .hit       (hit),
        .game_state(game_state),
        .target    (target),
        .score     (score),
        .misses    (misses)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        start = 1'b0;
        pause = 1'b0;
        hit   = 1'b0;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        tick;
        tests++; if (game_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b expected 00", game_state); end
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL reset_target: got %b expected 0", target); end
        tests++; if (score !== 8'd0) begin fails++; $display("FAIL reset_score: got %0d expected 0", score); end
        tests++; if (misses !== 8'd0) begin fails++; $display("FAIL reset_misses: got %0d expected 0", misses); end
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick; tick;
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL reset_holds_start: got target %b expected 0", target); end
    endtask

    task automatic test_timeout;
        logic exp_t;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_t = (c >= 5 && c <= 7) ? 1'b1 : 1'b0;
            tests++; if (target !== exp_t) begin fails++; $display("FAIL timeout_target c=%0d: got %b expected %b", c, target, exp_t); end
            tests++; if (game_state !== 2'b00) begin fails++; $display("FAIL timeout_state c=%0d: got %b expected 00", c, game_state); end
            if (c < 8) tick;
        end
        tests++; if (misses !== 8'd1) begin fails++; $display("FAIL timeout_misses: got %0d expected 1", misses); end
        tests++; if (score !== 8'd0) begin fails++; $display("FAIL timeout_score: got %0d expected 0", score); end
        tick; tick; tick; tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL timeout_rearm: got %b expected 1", target); end
    endtask

    task automatic test_win;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL win_armed1: got %b expected 1", target); end
        hit = 1'b1;
        tick;
        hit = 1'b0;
        tests++; if (score !== 8'd1) begin fails++; $display("FAIL win_score1: got %0d expected 1", score); end
        tests++; if (game_state !== 2'b00) begin fails++; $display("FAIL win_state1: got %b expected 00", game_state); end
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL win_target1: got %b expected 0", target); end
        repeat (5) tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL win_armed2: got %b expected 1", target); end
        hit = 1'b1;
        tick;
        hit = 1'b0;
        tests++; if (score !== 8'd2) begin fails++; $display("FAIL win_score2: got %0d expected 2", score); end
        tests++; if (game_state !== 2'b01) begin fails++; $display("FAIL win_state2: got %b expected 01", game_state); end
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL win_target2: got %b expected 0", target); end
        for (int i = 0; i < 3; i++) begin
            hit = 1'b1;
            tick;
            hit = 1'b0;
            tick;
            tests++; if (score !== 8'd2) begin fails++; $display("FAIL win_hold_score i=%0d: got %0d expected 2", i, score); end
            tests++; if (game_state !== 2'b01) begin fails++; $display("FAIL win_hold_state i=%0d: got %b expected 01", i, game_state); end
        end
    endtask

    task automatic test_early;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL early_lastwait: got %b expected 0", target); end
        hit = 1'b1;
        tick;
        hit = 1'b0;
        tests++; if (misses !== 8'd1) begin fails++; $display("FAIL early_miss1: got %0d expected 1", misses); end
        tests++; if (score !== 8'd0) begin fails++; $display("FAIL early_score: got %0d expected 0", score); end
        tests++; if (game_state !== 2'b00) begin fails++; $display("FAIL early_state1: got %b expected 00", game_state); end
        tick;
        hit = 1'b1;
        tick;
        hit = 1'b0;
        tests++; if (misses !== 8'd2) begin fails++; $display("FAIL early_miss2: got %0d expected 2", misses); end
        tests++; if (game_state !== 2'b10) begin fails++; $display("FAIL early_lose: got %b expected 10", game_state); end
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL early_target: got %b expected 0", target); end
        repeat (6) tick;
        tests++; if (game_state !== 2'b10 || misses !== 8'd2) begin fails++; $display("FAIL early_hold: got state %b misses %0d expected 10 and 2", game_state, misses); end
    endtask

    task automatic test_last_window;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (6) tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL lastwin_armed: got %b expected 1", target); end
        hit = 1'b1;
        tick;
        hit = 1'b0;
        tests++; if (score !== 8'd1) begin fails++; $display("FAIL lastwin_score: got %0d expected 1", score); end
        tests++; if (misses !== 8'd0) begin fails++; $display("FAIL lastwin_misses: got %0d expected 0", misses); end
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL lastwin_target: got %b expected 0", target); end
        repeat (3) tick;
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL lastwin_wait: got %b expected 0", target); end
        tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL lastwin_rearm: got %b expected 1", target); end
    endtask

    task automatic test_pause;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL pause_armed: got %b expected 1", target); end
        pause = 1'b1;
        #1;
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL pause_dark: got %b expected 0", target); end
        for (int i = 0; i < 10; i++) begin
            hit = i[0];
            tick;
            tests++; if (target !== 1'b0 || score !== 8'd0 || misses !== 8'd0) begin fails++; $display("FAIL pause_frozen i=%0d: got target %b score %0d misses %0d expected 0 0 0", i, target, score, misses); end
        end
        pause = 1'b0;
        hit   = 1'b0;
        #1;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL pause_resume0: got %b expected 1", target); end
        tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL pause_resume1: got %b expected 1", target); end
        tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL pause_resume2: got %b expected 1", target); end
        tick;
        tests++; if (target !== 1'b0 || misses !== 8'd1) begin fails++; $display("FAIL pause_timeout: got target %b misses %0d expected 0 1", target, misses); end
    endtask

    task automatic test_async_reset;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        hit = 1'b1;
        tick;
        hit = 1'b0;
        repeat (4) tick;
        tests++; if (target !== 1'b1 || score !== 8'd1) begin fails++; $display("FAIL areset_pre: got target %b score %0d expected 1 1", target, score); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (score !== 8'd0) begin fails++; $display("FAIL areset_score: got %0d expected 0", score); end
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL areset_target: got %b expected 0", target); end
        tests++; if (game_state !== 2'b00 || misses !== 8'd0) begin fails++; $display("FAIL areset_other: got state %b misses %0d expected 00 0", game_state, misses); end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        hit = 1'b1;
        tick;
        hit = 1'b0;
        repeat (5) tick;
        hit = 1'b1;
        tick;
        hit = 1'b0;
        tests++; if (game_state !== 2'b01 || score !== 8'd2) begin fails++; $display("FAIL restart_win: got state %b score %0d expected 01 2", game_state, score); end
        start = 1'b1;
        hit   = 1'b1;
        tick;
        start = 1'b0;
        hit   = 1'b0;
        tests++; if (game_state !== 2'b00) begin fails++; $display("FAIL restart_state: got %b expected 00", game_state); end
        tests++; if (score !== 8'd0 || misses !== 8'd0) begin fails++; $display("FAIL restart_counts: got score %0d misses %0d expected 0 0", score, misses); end
        repeat (3) tick;
        tests++; if (target !== 1'b0) begin fails++; $display("FAIL restart_wait: got %b expected 0", target); end
        tick;
        tests++; if (target !== 1'b1) begin fails++; $display("FAIL restart_armed: got %b expected 1", target); end
    endtask

    initial begin
        test_reset;
        test_timeout;
        test_win;
        test_early;
        test_last_window;
        test_pause;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
